// File: rtl/insn_mem_param.sv
// Parametrised instruction memory for the fetch stage: byte-addressed fetch with
// alignment/range faults, a stall-holdable registered output, a load port and a post-reset NOP sweep.
module insn_mem_param #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INSN = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    input  logic                     stall,
    output logic [DATA_W-1:0]        insn_out,
    output logic                     insn_valid,
    output logic [1:0]               insn_fault,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]        load_data,
    output logic                     init_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(DATA_W / 8);

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              init_done_q;

    logic [DATA_W-1:0] insn_q;
    logic              valid_q;
    logic [1:0]        fault_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  fetch_idx;
    logic              mis_align;
    logic              out_of_range;
    logic              fetch_accept;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    // Address decode: word index, byte offset and any bits above the array.
    assign fetch_idx = fetch_addr[OFF_W+IDX_W-1:OFF_W];

    generate
        if (OFF_W > 0) begin : g_offset
            assign mis_align = |fetch_addr[OFF_W-1:0];
        end else begin : g_no_offset
            assign mis_align = 1'b0;
        end

        if (ADDR_W > OFF_W + IDX_W) begin : g_upper
            assign out_of_range = |fetch_addr[ADDR_W-1:OFF_W+IDX_W];
        end else begin : g_no_upper
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign fetch_accept = (state_q == READY) && fetch_req && !stall;

    // The sweep owns the write port until it finishes; loads are only honoured in READY.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_data = NOP_INSN;
        if (state_q == SWEEP) begin
            wr_en = 1'b1;
        end else if (load_en) begin
            wr_en   = 1'b1;
            wr_idx  = load_addr;
            wr_data = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SWEEP;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                SWEEP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    state_q     <= READY;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= SWEEP;
                    cnt_q       <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Read sees the pre-edge array contents, so a same-cycle load returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insn_q  <= NOP_INSN;
            valid_q <= 1'b0;
            fault_q <= 2'b00;
        end else if (!stall) begin
            valid_q <= fetch_accept;
            if (fetch_accept) begin
                fault_q <= {out_of_range, mis_align};
                if (out_of_range || mis_align) begin
                    insn_q <= NOP_INSN;
                end else begin
                    insn_q <= mem[fetch_idx];
                end
            end
        end
    end

    assign insn_out   = insn_q;
    assign insn_valid = valid_q;
    assign insn_fault = fault_q;
    assign init_done  = init_done_q;

endmodule
